// File: rtl/bus_control_seq_8259.sv
// 8259 bus interface: synchronises the CPU write strobe, decodes each committed write
// into one-cycle command-word strobes and tracks the ICW1..ICW4 initialisation sequence.
module bus_control_seq_8259 #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  chip_select_n,
    input  logic                  read_enable_n,
    input  logic                  write_enable_n,
    input  logic                  address,
    input  logic [DATA_WIDTH-1:0] data_bus_in,
    output logic [DATA_WIDTH-1:0] internal_data_bus,
    output logic                  write_initial_command_word_1,
    output logic                  write_initial_command_word_2,
    output logic                  write_initial_command_word_3,
    output logic                  write_initial_command_word_4,
    output logic                  write_operation_control_word_1,
    output logic                  write_operation_control_word_2,
    output logic                  write_operation_control_word_3,
    output logic                  write_out,
    output logic                  read,
    output logic                  init_done,
    output logic                  single_mode,
    output logic                  icw4_needed,
    output logic                  protocol_error
);

    typedef enum logic [2:0] {
        UNINIT,
        WAIT_ICW2,
        WAIT_ICW3,
        WAIT_ICW4,
        READY
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  we_sync_q, we_sync_d;
    logic                    we_edge_q, we_edge_d;
    logic                    cs_cap_q, cs_cap_d;
    logic                    a0_cap_q, a0_cap_d;
    logic [DATA_WIDTH-1:0]   data_cap_q, data_cap_d;
    logic [DATA_WIDTH-1:0]   bus_q, bus_d;
    logic                    icw1_q, icw1_d, icw2_q, icw2_d, icw3_q, icw3_d, icw4_q, icw4_d;
    logic                    ocw1_q, ocw1_d, ocw2_q, ocw2_d, ocw3_q, ocw3_d;
    logic                    wout_q, wout_d;
    logic                    sngl_q, sngl_d, ic4_q, ic4_d, perr_q, perr_d;
    logic                    we_sync_out;
    logic                    commit;
    logic                    accept;

    assign we_sync_out = we_sync_q[SYNC_STAGES-1];
    // Commit on the synchronised rising edge; a deselected capture never commits.
    assign commit      = we_sync_out & ~we_edge_q & ~cs_cap_q;

    always_comb begin
        we_sync_d    = we_sync_q << 1;
        we_sync_d[0] = write_enable_n;
        we_edge_d    = we_sync_out;
        cs_cap_d     = write_enable_n ? cs_cap_q   : chip_select_n;
        a0_cap_d     = write_enable_n ? a0_cap_q   : address;
        data_cap_d   = write_enable_n ? data_cap_q : data_bus_in;
    end

    always_comb begin
        state_d = state_q;
        bus_d   = bus_q;
        sngl_d  = sngl_q;
        ic4_d   = ic4_q;
        perr_d  = perr_q;
        icw1_d  = 1'b0;
        icw2_d  = 1'b0;
        icw3_d  = 1'b0;
        icw4_d  = 1'b0;
        ocw1_d  = 1'b0;
        ocw2_d  = 1'b0;
        ocw3_d  = 1'b0;
        accept  = 1'b0;
        if (commit) begin
            if (!a0_cap_q && data_cap_q[4]) begin
                icw1_d  = 1'b1;
                accept  = 1'b1;
                ic4_d   = data_cap_q[0];
                sngl_d  = data_cap_q[1];
                perr_d  = 1'b0;
                state_d = WAIT_ICW2;
            end else begin
                unique case (state_q)
                    UNINIT: perr_d = 1'b1;
                    WAIT_ICW2: if (a0_cap_q) begin
                        icw2_d = 1'b1;
                        accept = 1'b1;
                        if (!sngl_q)     state_d = WAIT_ICW3;
                        else if (ic4_q)  state_d = WAIT_ICW4;
                        else             state_d = READY;
                    end
                    WAIT_ICW3: if (a0_cap_q) begin
                        icw3_d  = 1'b1;
                        accept  = 1'b1;
                        state_d = ic4_q ? WAIT_ICW4 : READY;
                    end
                    WAIT_ICW4: if (a0_cap_q) begin
                        icw4_d  = 1'b1;
                        accept  = 1'b1;
                        state_d = READY;
                    end
                    READY: begin
                        accept = 1'b1;
                        if (a0_cap_q)           ocw1_d = 1'b1;
                        else if (data_cap_q[3]) ocw3_d = 1'b1;
                        else                    ocw2_d = 1'b1;
                    end
                    default: state_d = UNINIT;
                endcase
            end
        end
        wout_d = accept;
        if (accept) bus_d = data_cap_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= UNINIT;
            we_sync_q  <= '1;
            we_edge_q  <= 1'b1;
            cs_cap_q   <= 1'b1;
            a0_cap_q   <= 1'b0;
            data_cap_q <= '0;
            bus_q      <= '0;
            icw1_q     <= 1'b0;
            icw2_q     <= 1'b0;
            icw3_q     <= 1'b0;
            icw4_q     <= 1'b0;
            ocw1_q     <= 1'b0;
            ocw2_q     <= 1'b0;
            ocw3_q     <= 1'b0;
            wout_q     <= 1'b0;
            sngl_q     <= 1'b0;
            ic4_q      <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_sync_q  <= we_sync_d;
            we_edge_q  <= we_edge_d;
            cs_cap_q   <= cs_cap_d;
            a0_cap_q   <= a0_cap_d;
            data_cap_q <= data_cap_d;
            bus_q      <= bus_d;
            icw1_q     <= icw1_d;
            icw2_q     <= icw2_d;
            icw3_q     <= icw3_d;
            icw4_q     <= icw4_d;
            ocw1_q     <= ocw1_d;
            ocw2_q     <= ocw2_d;
            ocw3_q     <= ocw3_d;
            wout_q     <= wout_d;
            sngl_q     <= sngl_d;
            ic4_q      <= ic4_d;
            perr_q     <= perr_d;
        end
    end

    assign internal_data_bus              = bus_q;
    assign write_initial_command_word_1   = icw1_q;
    assign write_initial_command_word_2   = icw2_q;
    assign write_initial_command_word_3   = icw3_q;
    assign write_initial_command_word_4   = icw4_q;
    assign write_operation_control_word_1 = ocw1_q;
    assign write_operation_control_word_2 = ocw2_q;
    assign write_operation_control_word_3 = ocw3_q;
    assign write_out                      = wout_q;
    assign read                           = ~chip_select_n & ~read_enable_n;
    assign init_done                      = (state_q == READY);
    assign single_mode                    = sngl_q;
    assign icw4_needed                    = ic4_q;
    assign protocol_error                 = perr_q;

endmodule

// File: tb/tb_bus_control_seq_8259.sv
// Randomised self-checking bench for bus_control_seq_8259 against a queue-based
// model of the initialisation sequence.
module tb_bus_control_seq_8259;
    localparam int DW = 8;
    localparam int S  = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          chip_select_n, read_enable_n, write_enable_n, address;
    logic [DW-1:0] data_bus_in;
    logic [DW-1:0] internal_data_bus;
    logic icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3, write_out, read;
    logic init_done, single_mode, icw4_needed, protocol_error;

    bus_control_seq_8259 #(.DATA_WIDTH(DW), .SYNC_STAGES(S)) dut (
        .clock(clock), .reset(reset),
        .chip_select_n(chip_select_n), .read_enable_n(read_enable_n),
        .write_enable_n(write_enable_n), .address(address), .data_bus_in(data_bus_in),
        .internal_data_bus(internal_data_bus),
        .write_initial_command_word_1(icw1), .write_initial_command_word_2(icw2),
        .write_initial_command_word_3(icw3), .write_initial_command_word_4(icw4),
        .write_operation_control_word_1(ocw1), .write_operation_control_word_2(ocw2),
        .write_operation_control_word_3(ocw3), .write_out(write_out), .read(read),
        .init_done(init_done), .single_mode(single_mode), .icw4_needed(icw4_needed),
        .protocol_error(protocol_error)
    );

    always #5 clock = ~clock;

    // Strobe vector: {ICW1, ICW2, ICW3, ICW4, OCW1, OCW2, OCW3, write_out}
    wire [7:0] strobes = {icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3, write_out};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: the A0=1 words still owed after ICW1 are kept as a queue of
    // strobe numbers (2=ICW2, 3=ICW3, 4=ICW4); an empty queue after ICW1 means ready.
    int            m_pend[$];
    bit            m_uninit;
    bit            m_sngl, m_ic4, m_perr;
    logic [DW-1:0] m_bus;

    function automatic logic [7:0] strobe_of(input int k);
        logic [7:0] top;
        top = 8'h80;
        return (top >> (k - 1)) | 8'h01;
    endfunction

    task automatic model_reset();
        m_pend.delete();
        m_uninit = 1'b1;
        m_sngl = 1'b0;
        m_ic4 = 1'b0;
        m_perr = 1'b0;
        m_bus = '0;
    endtask

    task automatic model_write(input bit cs_n, input bit a0, input logic [DW-1:0] d,
                               output logic [7:0] exp);
        exp = 8'h00;
        if (cs_n) return;
        if (!a0 && d[4]) begin
            m_uninit = 1'b0;
            m_sngl = d[1];
            m_ic4 = d[0];
            m_perr = 1'b0;
            m_pend.delete();
            m_pend.push_back(2);
            if (!d[1]) m_pend.push_back(3);
            if (d[0])  m_pend.push_back(4);
            exp = strobe_of(1);
            m_bus = d;
        end else if (m_uninit) begin
            m_perr = 1'b1;
        end else if (m_pend.size() != 0) begin
            if (a0) begin
                exp = strobe_of(m_pend.pop_front());
                m_bus = d;
            end
        end else begin
            exp = a0 ? strobe_of(5) : (d[3] ? strobe_of(7) : strobe_of(6));
            m_bus = d;
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, ".bus"},  internal_data_bus, m_bus);
        check({tag, ".done"}, init_done, !m_uninit && m_pend.size() == 0);
        check({tag, ".sngl"}, single_mode, m_sngl);
        check({tag, ".ic4"},  icw4_needed, m_ic4);
        check({tag, ".perr"}, protocol_error, m_perr);
    endtask

    // One CPU write: strobe low for 3 clocks, then watch the strobe vector each cycle.
    task automatic cpu_write(input string tag, input bit cs_n, input bit a0,
                             input logic [DW-1:0] d, input bit rd_n);
        logic [7:0] exp;
        model_write(cs_n, a0, d, exp);
        @(negedge clock);
        chip_select_n  = cs_n;
        address        = a0;
        data_bus_in    = d;
        read_enable_n  = rd_n;
        write_enable_n = 1'b0;
        repeat (3) @(negedge clock);
        write_enable_n = 1'b1;
        #1;
        check({tag, ".read"}, read, !cs_n && !rd_n);
        chip_select_n = 1'b1;
        read_enable_n = 1'b1;
        address       = $urandom_range(1);
        data_bus_in   = DW'($urandom);
        for (int j = 0; j <= S + 2; j++) begin
            @(negedge clock);
            check($sformatf("%s.strobe%0d", tag, j), strobes, (j == S) ? exp : 8'h00);
        end
        check_status(tag);
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2 reset = 1'b1;
        model_reset();
        #1;
        check("rst.strobes", strobes, 8'h00);
        check_status("rst");
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        chip_select_n = 1'b1;
        read_enable_n = 1'b1;
        write_enable_n = 1'b1;
        address = 1'b0;
        data_bus_in = '0;
        model_reset();
        repeat (2) @(negedge clock);
        check("por.strobes", strobes, 8'h00);
        check_status("por");
        reset = 1'b0;

        // ICW1 with SNGL and IC4, no ICW3 expected
        cpu_write("icw1_13", 1'b0, 1'b0, 8'h13, 1'b1);
        cpu_write("icw2_20", 1'b0, 1'b1, 8'h20, 1'b1);
        cpu_write("icw4_01", 1'b0, 1'b1, 8'h01, 1'b0);
        // Cascade mode without ICW4
        cpu_write("icw1_10", 1'b0, 1'b0, 8'h10, 1'b1);
        cpu_write("icw2_08", 1'b0, 1'b1, 8'h08, 1'b1);
        cpu_write("icw3_04", 1'b0, 1'b1, 8'h04, 1'b1);
        cpu_write("ocw1",    1'b0, 1'b1, 8'hFB, 1'b0);
        cpu_write("ocw2",    1'b0, 1'b0, 8'h20, 1'b1);
        cpu_write("ocw3",    1'b0, 1'b0, 8'h0B, 1'b1);
        cpu_write("cs_hi",   1'b1, 1'b1, 8'hAA, 1'b0);
        // ICW1 restart mid-sequence, plus an ignored A0=0 word while waiting
        cpu_write("re_icw1", 1'b0, 1'b0, 8'h10, 1'b1);
        cpu_write("re_icw2", 1'b0, 1'b1, 8'h30, 1'b1);
        cpu_write("ign_ocw", 1'b0, 1'b0, 8'h08, 1'b1);
        cpu_write("mid_icw1", 1'b0, 1'b0, 8'h11, 1'b1);
        // Protocol error before initialisation, cleared by ICW1
        do_reset();
        cpu_write("perr_55", 1'b0, 1'b1, 8'h55, 1'b1);
        cpu_write("perr_ocw", 1'b0, 1'b0, 8'h0B, 1'b1);
        cpu_write("perr_clr", 1'b0, 1'b0, 8'h13, 1'b1);
        cpu_write("w4_icw2", 1'b0, 1'b1, 8'h40, 1'b1);
        // Reset while waiting for ICW4
        do_reset();

        for (int i = 0; i < 150; i++) begin
            logic [DW-1:0] d;
            bit cs_n, a0;
            d    = DW'($urandom);
            cs_n = ($urandom_range(7) == 0);
            a0   = $urandom_range(1);
            // Keep restarts infrequent so sequences usually run to completion
            if (!a0 && d[4] && $urandom_range(2) != 0) d[4] = 1'b0;
            cpu_write($sformatf("rnd%0d", i), cs_n, a0, d, $urandom_range(1));
            if ($urandom_range(40) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
